// File: rtl/fpu_isqrt_pkg.sv
// Shared types and constants for the inverse-square-root unit arbiter.
//   HALF_W    : half-precision operand width
//   HALF_QNAN : quiet NaN returned when the unit never reports done
//   arb_state_t : controller states
package fpu_isqrt_pkg;

    localparam int unsigned HALF_W = 16;
    localparam logic [HALF_W-1:0] HALF_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/fpu_isqrt_arbiter_rr.sv
// Combinational round-robin grant: picks the first asserted request at or
// after ptr, wrapping modulo NREQ.
//   req : request vector
//   ptr : highest-priority index
//   gnt : one-hot grant
//   idx : binary index of the grant
//   any : at least one request present
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int unsigned j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = (32'(ptr) + 32'(i)) % NREQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_isqrt_arbiter.sv
// Shares one inverse-square-root unit between NREQ requesters. Grants
// round-robin, holds the operand on unit_x, pulses unit_start (the unit's
// reset) for START_CYCLES, waits for unit_done and returns the result over
// a valid/ready response channel. One operation in flight at a time.
// Optional macro FPU_ISQRT_ARB_TIMEOUT_EN adds a wait-for-done timeout that
// answers with qNaN and rsp_err=1 after TIMEOUT_CYCLES cycles in WAIT.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_x     : per-requester operand valid and operands
//   req_ready           : one-hot accept pulse (IDLE only)
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/result/ofuf/err : response payload
//   busy                : controller not in IDLE
//   unit_x/unit_start   : operand and reset to the unit
//   unit_done/result/ofuf : status and results from the unit
module fpu_isqrt_arbiter
    import fpu_isqrt_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned START_CYCLES   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned IDW           = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [HALF_W*NREQ-1:0] req_x,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [HALF_W-1:0]      rsp_result,
    output logic [1:0]             rsp_ofuf,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [HALF_W-1:0]      unit_x,
    output logic                   unit_start,
    input  logic                   unit_done,
    input  logic [HALF_W-1:0]      unit_result,
    input  logic [1:0]             unit_ofuf
);

    localparam int unsigned SCW = 2;

    if (NREQ < 2 || NREQ > 8 || START_CYCLES < 1 || START_CYCLES > 4 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fpu_isqrt_arbiter: parameter out of range");
    end

    arb_state_t      state;
    logic [IDW-1:0]  ptr;
    logic [SCW-1:0]  start_cnt;
    logic [NREQ-1:0] gnt_c;
    logic [IDW-1:0]  gidx_c;
    logic            gany_c;
    logic [IDW-1:0]  ptr_next_c;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt_c),
        .idx (gidx_c),
        .any (gany_c)
    );

    // Accept pulse is only meaningful in IDLE and never while in reset.
    assign req_ready  = (state == IDLE && !reset) ? gnt_c : '0;
    // Unit is reset together with the controller.
    assign unit_start = reset || (state == START);
    assign busy       = (state != IDLE);
    assign rsp_valid  = (state == RESP);
    assign ptr_next_c = (rsp_id == IDW'(NREQ - 1)) ? '0 : IDW'(rsp_id + 1'b1);

`ifdef FPU_ISQRT_ARB_TIMEOUT_EN
    localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] to_cnt;
    logic           err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Controller FSM and payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            start_cnt  <= '0;
            unit_x     <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_ofuf   <= '0;
`ifdef FPU_ISQRT_ARB_TIMEOUT_EN
            to_cnt     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gany_c) begin
                        unit_x    <= req_x[HALF_W*gidx_c +: HALF_W];
                        rsp_id    <= gidx_c;
                        start_cnt <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    if (start_cnt == SCW'(START_CYCLES - 1)) begin
`ifdef FPU_ISQRT_ARB_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        state  <= WAIT;
                    end else begin
                        start_cnt <= start_cnt + SCW'(1);
                    end
                end
                WAIT: begin
                    if (unit_done) begin
                        rsp_result <= unit_result;
                        rsp_ofuf   <= unit_ofuf;
`ifdef FPU_ISQRT_ARB_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                        state      <= RESP;
                    end
`ifdef FPU_ISQRT_ARB_TIMEOUT_EN
                    else if (to_cnt == TOW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_result <= HALF_QNAN;
                        rsp_ofuf   <= 2'b00;
                        err_q      <= 1'b1;
                        state      <= RESP;
                    end else begin
                        to_cnt <= to_cnt + TOW'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        ptr   <= ptr_next_c;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
